// File: rtl/gfau_exp_ctrl.sv
// rtl/gfau_exp_ctrl.sv - left-to-right square-and-multiply sequencer driving the GFAU handshake
// Computes base^exp mod prime with one GFAU multiply in flight at a time.
module gfau_exp_ctrl #(
    parameter int         DATA_W = 32,
    parameter int         TO_W   = 8,
    parameter logic [1:0] OP_MUL = 2'd2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [DATA_W-1:0] i_base,
    input  logic [DATA_W-1:0] i_exp,
    input  logic [DATA_W-1:0] i_prime,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    output logic [DATA_W-1:0] o_result,
    output logic              done_from_control,
    output logic [DATA_W-1:0] in_0,
    output logic [DATA_W-1:0] in_1,
    output logic [DATA_W-1:0] prime,
    output logic [1:0]        operation_select,
    input  logic              done_to_control,
    input  logic [DATA_W-1:0] result
);

    localparam int                BIT_W   = $clog2(DATA_W);
    localparam logic [DATA_W-1:0] ONE     = DATA_W'(1);
    localparam logic [TO_W-1:0]   WD_LAST = {{(TO_W-1){1'b1}}, 1'b0};

    typedef enum logic [2:0] {
        IDLE,
        SQ_ISSUE,
        SQ_WAIT,
        MUL_ISSUE,
        MUL_WAIT,
        DONE
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] base_q;
    logic [DATA_W-1:0] exp_q;
    logic [DATA_W-1:0] prime_q;
    logic [DATA_W-1:0] acc;
    logic [BIT_W-1:0]  bit_idx;
    logic [TO_W-1:0]   wd_cnt;

    logic [BIT_W-1:0]  msb_idx;
    logic              exp_trivial;
    logic              mul_next;

    // Later hits overwrite earlier ones, so the highest set bit wins.
    always_comb begin
        msb_idx = '0;
        for (int i = 0; i < DATA_W; i++) begin
            if (i_exp[i]) begin
                msb_idx = BIT_W'(i);
            end
        end
    end

    assign exp_trivial = (i_exp[DATA_W-1:1] == '0);
    assign mul_next    = (state == SQ_WAIT) && exp_q[bit_idx];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state             <= IDLE;
            base_q            <= '0;
            exp_q             <= '0;
            prime_q           <= '0;
            acc               <= '0;
            bit_idx           <= '0;
            wd_cnt            <= '0;
            o_busy            <= 1'b0;
            o_done            <= 1'b0;
            o_err             <= 1'b0;
            o_result          <= '0;
            done_from_control <= 1'b0;
            in_0              <= '0;
            in_1              <= '0;
            prime             <= '0;
            operation_select  <= OP_MUL;
        end else begin
            done_from_control <= 1'b0;
            o_done            <= 1'b0;
            operation_select  <= OP_MUL;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        base_q  <= i_base;
                        exp_q   <= i_exp;
                        prime_q <= i_prime;
                        o_err   <= 1'b0;
                        o_busy  <= 1'b1;
                        if (exp_trivial) begin
                            acc      <= i_exp[0] ? i_base : ONE;
                            o_result <= i_exp[0] ? i_base : ONE;
                            bit_idx  <= msb_idx;
                            o_done   <= 1'b1;
                            state    <= DONE;
                        end else begin
                            acc               <= i_base;
                            bit_idx           <= msb_idx - 1'b1;
                            in_0              <= i_base;
                            in_1              <= i_base;
                            prime             <= i_prime;
                            done_from_control <= 1'b1;
                            state             <= SQ_ISSUE;
                        end
                    end
                end
                SQ_ISSUE: begin
                    wd_cnt <= '0;
                    state  <= SQ_WAIT;
                end
                MUL_ISSUE: begin
                    wd_cnt <= '0;
                    state  <= MUL_WAIT;
                end
                SQ_WAIT, MUL_WAIT: begin
                    if (done_to_control) begin
                        acc <= result;
                        if (mul_next) begin
                            in_0              <= result;
                            in_1              <= base_q;
                            prime             <= prime_q;
                            done_from_control <= 1'b1;
                            state             <= MUL_ISSUE;
                        end else if (bit_idx == '0) begin
                            o_result <= result;
                            o_done   <= 1'b1;
                            state    <= DONE;
                        end else begin
                            bit_idx           <= bit_idx - 1'b1;
                            in_0              <= result;
                            in_1              <= result;
                            prime             <= prime_q;
                            done_from_control <= 1'b1;
                            state             <= SQ_ISSUE;
                        end
                    end else if (wd_cnt == WD_LAST) begin
                        // The GFAU went silent: report the partial accumulator.
                        o_err    <= 1'b1;
                        o_result <= acc;
                        o_done   <= 1'b1;
                        state    <= DONE;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                DONE: begin
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gfau_exp_ctrl.sv
// tb/tb_gfau_exp_ctrl.sv - scoreboard bench for gfau_exp_ctrl with a behavioural GFAU model
// Expected results are queued at start and compared when o_done pulses.
module tb_gfau_exp_ctrl;

    typedef struct {
        logic [31:0] res;
        logic        err;
        int          ops;
    } exp_t;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_start = 1'b0;
    logic [31:0] i_base = '0;
    logic [31:0] i_exp = '0;
    logic [31:0] i_prime = '0;
    logic        o_busy;
    logic        o_done;
    logic        o_err;
    logic [31:0] o_result;
    logic        done_from_control;
    logic [31:0] in_0;
    logic [31:0] in_1;
    logic [31:0] prime;
    logic [1:0]  operation_select;
    logic        done_to_control = 1'b0;
    logic [31:0] result = '0;

    int chk_cnt = 0;
    int err_cnt = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int start_cnt = 0;
    int acc_cyc = 0;
    int issue_cnt = 0;
    int first_issue_cyc = 0;
    int last_resp_cyc = 0;
    int unstable = 0;
    int lat_fixed = 3;
    bit lat_random = 1'b0;
    bit mute = 1'b0;

    exp_t        sb_q[$];
    logic [31:0] prod_q[$];

    gfau_exp_ctrl dut (
        .i_clk             (i_clk),
        .i_rst             (i_rst),
        .i_start           (i_start),
        .i_base            (i_base),
        .i_exp             (i_exp),
        .i_prime           (i_prime),
        .o_busy            (o_busy),
        .o_done            (o_done),
        .o_err             (o_err),
        .o_result          (o_result),
        .done_from_control (done_from_control),
        .in_0              (in_0),
        .in_1              (in_1),
        .prime             (prime),
        .operation_select  (operation_select),
        .done_to_control   (done_to_control),
        .result            (result)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        chk_cnt++;
        if (got !== want) begin
            err_cnt++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, want, want);
        end
    endtask

    function automatic logic [31:0] mulmod(input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] p);
        logic [63:0] t;
        t = (64'(a) * 64'(b)) % 64'(p);
        return t[31:0];
    endfunction

    // Right-to-left reference, deliberately a different walk from the DUT.
    function automatic logic [31:0] ref_pow(input logic [31:0] b, input logic [31:0] e,
                                            input logic [31:0] p);
        logic [31:0] r;
        logic [31:0] x;
        r = 32'd1;
        x = b;
        for (int i = 0; i < 32; i++) begin
            if (e[i]) r = mulmod(r, x, p);
            x = mulmod(x, x, p);
        end
        return r;
    endfunction

    function automatic int ref_ops(input logic [31:0] e);
        int k;
        int pc;
        k = 0;
        pc = 0;
        for (int i = 0; i < 32; i++) begin
            if (e[i]) begin
                k = i;
                pc++;
            end
        end
        return (e < 32'd2) ? 0 : k + pc - 1;
    endfunction

    // GFAU model: responds L cycles after the issue edge with the true product.
    logic [31:0] rec0, rec1, recp, rec_res;
    int          pend = 0;
    bit          prev_issue = 1'b0;
    always @(negedge i_clk) begin
        done_to_control = 1'b0;
        result = $urandom;
        if (pend > 0) begin
            if (in_0 !== rec0 || in_1 !== rec1 || prime !== recp) unstable++;
            pend--;
            if (pend == 0) begin
                done_to_control = 1'b1;
                result = rec_res;
                prod_q.push_back(rec_res);
                last_resp_cyc = cyc;
            end
        end
        if (done_from_control) begin
            if (issue_cnt == 0) first_issue_cyc = cyc;
            issue_cnt++;
            if (prev_issue) unstable++;
            rec0 = in_0;
            rec1 = in_1;
            recp = prime;
            rec_res = mulmod(in_0, in_1, prime);
            if (!mute) pend = lat_random ? int'($urandom_range(1, 7)) : lat_fixed;
        end
        prev_issue = done_from_control;
    end

    always @(negedge i_clk) begin
        if (!i_rst && o_done) begin
            exp_t x;
            done_cyc = cyc;
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_done", 1, 0);
            end else begin
                x = sb_q.pop_front();
                chk("result", o_result, x.res);
                chk("err", o_err, x.err);
                chk("op_count", issue_cnt, x.ops);
            end
            done_cnt++;
        end
    end

    task automatic start_op(input logic [31:0] b, input logic [31:0] e, input logic [31:0] p);
        issue_cnt = 0;
        unstable = 0;
        prod_q.delete();
        start_cnt = done_cnt;
        i_base = b;
        i_exp = e;
        i_prime = p;
        i_start = 1'b1;
        @(negedge i_clk); #1;
        i_start = 1'b0;
        acc_cyc = cyc;
    endtask

    task automatic wait_done(input int restart_at);
        for (int i = 0; i < 4000 && done_cnt == start_cnt; i++) begin
            i_start = (i == restart_at);
            if (i == restart_at) i_base = i_base + 32'd1;
            @(negedge i_clk); #1;
        end
        i_start = 1'b0;
        chk("done_seen", done_cnt != start_cnt, 1);
        @(negedge i_clk); #1;
        chk("done_one_cycle", o_done, 0);
        chk("idle_after_done", o_busy, 0);
        chk("operand_stable", unstable, 0);
    endtask

    task automatic run_exp(input logic [31:0] b, input logic [31:0] e, input logic [31:0] p,
                           input int restart_at);
        exp_t x;
        x.res = ref_pow(b, e, p);
        x.err = 1'b0;
        x.ops = ref_ops(e);
        sb_q.push_back(x);
        start_op(b, e, p);
        wait_done(restart_at);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, o_busy, 0);
        chk({tag, "_done"}, o_done, 0);
        chk({tag, "_err"}, o_err, 0);
        chk({tag, "_result"}, o_result, 0);
        chk({tag, "_issue"}, done_from_control, 0);
        chk({tag, "_in0"}, in_0, 0);
        chk({tag, "_in1"}, in_1, 0);
        chk({tag, "_prime"}, prime, 0);
        chk({tag, "_opsel"}, operation_select, 2);
    endtask

    initial begin
        logic [31:0] basic_prod [5];
        logic [31:0] rb, re;
        exp_t        tx;
        basic_prod = '{32'd9, 32'd10, 32'd15, 32'd4, 32'd12};

        repeat (3) @(negedge i_clk);
        #1;
        chk_reset_outputs("reset");
        i_rst = 1'b0;
        @(negedge i_clk); #1;

        // 3^13 mod 17 with a stray start pulse in the middle
        lat_fixed = 3;
        run_exp(32'd3, 32'd13, 32'd17, 6);
        chk("basic_prod_count", prod_q.size(), 5);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("basic_prod%0d", i), (i < prod_q.size()) ? prod_q[i] : 32'hDEAD, basic_prod[i]);
        end
        chk("basic_done_latency", done_cyc, last_resp_cyc + 1);

        run_exp(32'd5, 32'd0, 32'd17, -1);
        chk("exp0_latency", done_cyc, acc_cyc);
        run_exp(32'd5, 32'd1, 32'd17, -1);
        chk("exp1_latency", done_cyc, acc_cyc);

        lat_random = 1'b1;
        run_exp(32'd2, 32'hFFFF_FFFA, 32'hFFFF_FFFB, -1);
        for (int n = 0; n < 4; n++) begin
            rb = $urandom_range(1, 65520);
            re = $urandom;
            run_exp(rb, re, 32'd65521, -1);
        end
        lat_random = 1'b0;

        // GFAU never answers
        mute = 1'b1;
        tx.res = 32'd7;
        tx.err = 1'b1;
        tx.ops = 1;
        sb_q.push_back(tx);
        start_op(32'd7, 32'd5, 32'd17);
        wait_done(-1);
        chk("timeout_latency", done_cyc - first_issue_cyc, 256);
        mute = 1'b0;

        // Reset during SQ_WAIT with a response landing right after
        lat_fixed = 2;
        start_op(32'd3, 32'd13, 32'd17);
        for (int i = 0; i < 50 && issue_cnt == 0; i++) begin
            @(negedge i_clk); #1;
        end
        chk("rst_issue_seen", issue_cnt, 1);
        @(negedge i_clk); #1;
        i_rst = 1'b1;
        #1;
        chk_reset_outputs("midrst");
        @(negedge i_clk); #1;
        chk("late_resp_present", done_to_control, 1);
        i_rst = 1'b0;
        @(negedge i_clk); #1;
        chk("late_resp_busy", o_busy, 0);
        chk("late_resp_issue", done_from_control, 0);
        chk("late_resp_result", o_result, 0);
        chk("late_resp_no_done", done_cnt, start_cnt);
        repeat (2) @(negedge i_clk);
        #1;

        lat_fixed = 3;
        run_exp(32'd3, 32'd13, 32'd17, -1);
        chk("sb_drained", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
        $finish;
    end

endmodule
